// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined IEEE-754 add/subtract with valid/ready streams and status flags.
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52,
  parameter int unsigned W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int unsigned MW   = MAN_W + 4;          // hidden + fraction + guard/round/sticky
  localparam int unsigned SH_W = $clog2(MW + 1);
  localparam int unsigned EE_W = EXP_W + 2;          // two's-complement working exponent
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EE_W-1:0]  E_INF   = {2'b00, EXP_MAX};
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall, adv;
  logic v1, v2, v3;

  assign stall     = v3 & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = v3;

  // S1: unpack, decode specials, order operands by magnitude and align Y to X
  logic [EXP_W-1:0] ea, eb, ex_c, d_c;
  logic [MAN_W-1:0] fa, fb;
  logic [W-2:0]     ka, kb;
  logic [MW-1:0]    mant_a, mant_b, mx_c, my_c, my_sh_c;
  logic [SH_W-1:0]  dcl_c;
  logic             sa, sb, za, zb, ia, ib, na, nb, a_big, sx_c, sy_c, sticky_c;
  logic             spec_c, inv_c;
  logic [W-1:0]     spec_res_c;

  always_comb begin
    sa     = a[W-1];
    sb     = b[W-1] ^ op_sub;
    ea     = a[W-2:MAN_W];
    eb     = b[W-2:MAN_W];
    fa     = a[MAN_W-1:0];
    fb     = b[MAN_W-1:0];
    za     = (ea == '0);
    zb     = (eb == '0);
    na     = (ea == EXP_MAX) && (fa != '0);
    nb     = (eb == EXP_MAX) && (fb != '0);
    ia     = (ea == EXP_MAX) && (fa == '0);
    ib     = (eb == EXP_MAX) && (fb == '0);
    ka     = za ? '0 : {ea, fa};
    kb     = zb ? '0 : {eb, fb};
    mant_a = za ? '0 : {1'b1, fa, 3'b000};
    mant_b = zb ? '0 : {1'b1, fb, 3'b000};
    a_big  = (ka >= kb);
    if (a_big) begin
      sx_c = sa;
      sy_c = sb;
      ex_c = ea;
      d_c  = ea - eb;
      mx_c = mant_a;
      my_c = mant_b;
    end else begin
      sx_c = sb;
      sy_c = sa;
      ex_c = eb;
      d_c  = eb - ea;
      mx_c = mant_b;
      my_c = mant_a;
    end
    // Clamping the shift at MW-1 leaves a lone sticky bit for any far-smaller Y
    dcl_c    = (d_c > EXP_W'(MW - 1)) ? SH_W'(MW - 1) : SH_W'(d_c);
    my_sh_c  = my_c >> dcl_c;
    sticky_c = |(my_c << (SH_W'(MW) - dcl_c));

    spec_c     = 1'b0;
    inv_c      = 1'b0;
    spec_res_c = '0;
    if (na || nb || (ia && ib && (sa != sb))) begin
      spec_c     = 1'b1;
      inv_c      = 1'b1;
      spec_res_c = QNAN;
    end else if (ia) begin
      spec_c     = 1'b1;
      spec_res_c = {sa, EXP_MAX, {MAN_W{1'b0}}};
    end else if (ib) begin
      spec_c     = 1'b1;
      spec_res_c = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end else if (za && zb) begin
      spec_c     = 1'b1;
      spec_res_c = {sa & sb, {(W-1){1'b0}}};
    end
  end

  logic             s1_sx, s1_eop, s1_spec, s1_inv;
  logic [EXP_W-1:0] s1_ex;
  logic [MW-1:0]    s1_mx, s1_my;
  logic [W-1:0]     s1_spec_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      s1_sx       <= 1'b0;
      s1_eop      <= 1'b0;
      s1_spec     <= 1'b0;
      s1_inv      <= 1'b0;
      s1_ex       <= '0;
      s1_mx       <= '0;
      s1_my       <= '0;
      s1_spec_res <= '0;
    end else if (adv) begin
      v1          <= in_valid;
      s1_sx       <= sx_c;
      s1_eop      <= sx_c ^ sy_c;
      s1_spec     <= spec_c;
      s1_inv      <= inv_c;
      s1_ex       <= ex_c;
      s1_mx       <= mx_c;
      s1_my       <= {my_sh_c[MW-1:1], my_sh_c[0] | sticky_c};
      s1_spec_res <= spec_res_c;
    end
  end

  // S2: magnitude add/subtract (X >= Y so never negative) and leading-zero count
  logic [MW:0]     sum_c;
  logic [SH_W-1:0] lzc_c;

  always_comb begin
    if (s1_eop) sum_c = {1'b0, s1_mx} - {1'b0, s1_my};
    else        sum_c = {1'b0, s1_mx} + {1'b0, s1_my};
    lzc_c = SH_W'(MW);
    for (int i = 0; i < int'(MW); i++) begin
      if (sum_c[i]) lzc_c = SH_W'(int'(MW) - 1 - i);
    end
  end

  logic             s2_sign, s2_spec, s2_inv;
  logic [EXP_W-1:0] s2_ex;
  logic [MW:0]      s2_sum;
  logic [SH_W-1:0]  s2_lzc;
  logic [W-1:0]     s2_spec_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2          <= 1'b0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_inv      <= 1'b0;
      s2_ex       <= '0;
      s2_sum      <= '0;
      s2_lzc      <= '0;
      s2_spec_res <= '0;
    end else if (adv) begin
      v2          <= v1;
      s2_sign     <= s1_sx;
      s2_spec     <= s1_spec;
      s2_inv      <= s1_inv;
      s2_ex       <= s1_ex;
      s2_sum      <= sum_c;
      s2_lzc      <= lzc_c;
      s2_spec_res <= s1_spec_res;
    end
  end

  // S3: normalise, round, range-check and pack
  logic [MW-1:0]    norm_c;
  logic [EE_W-1:0]  e_n_c, e_r_c;
  logic [MAN_W+1:0] rnd_c;
  logic [MAN_W-1:0] frac_c;
  logic             inc_c, inexact_c;
  logic [W-1:0]     res_c;
  logic [3:0]       flg_c;

  always_comb begin
    if (s2_sum[MW]) begin
      norm_c = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
      e_n_c  = EE_W'(s2_ex) + EE_W'(1);
    end else begin
      norm_c = s2_sum[MW-1:0] << s2_lzc;
      e_n_c  = EE_W'(s2_ex) - EE_W'(s2_lzc);
    end
    inexact_c = |norm_c[2:0];
`ifdef FP_ADD_RNE_EN
    inc_c = norm_c[2] & (norm_c[1] | norm_c[0] | norm_c[3]);
`else
    inc_c = 1'b0;
`endif
    rnd_c  = {1'b0, norm_c[MW-1:3]} + (MAN_W+2)'(inc_c);
    e_r_c  = rnd_c[MAN_W+1] ? e_n_c + EE_W'(1) : e_n_c;
    frac_c = rnd_c[MAN_W+1] ? rnd_c[MAN_W:1] : rnd_c[MAN_W-1:0];

    res_c = '0;
    flg_c = '0;
    if (s2_spec) begin
      res_c = s2_spec_res;
      flg_c = {s2_inv, 3'b000};
    end else if (s2_sum == '0) begin
      res_c = '0;
    end else if (e_n_c[EE_W-1] || (e_n_c == '0)) begin
      res_c = {s2_sign, {(W-1){1'b0}}};
      flg_c = 4'b0011;
    end else if (e_r_c >= E_INF) begin
      res_c = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      flg_c = 4'b0101;
    end else begin
      res_c = {s2_sign, e_r_c[EXP_W-1:0], frac_c};
      flg_c = {3'b000, inexact_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3     <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else if (adv) begin
      v3     <= v2;
      result <= res_c;
      flags  <= flg_c;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed vector table, randomized scoreboard stream, stall and reset sequences.
// Expected values come from hand-derived constants and an exact-integer reference model.
module tb_fp_add_pipe;

  localparam int unsigned EXP_W = 11;
  localparam int unsigned MAN_W = 52;
  localparam int unsigned W     = 64;
  localparam logic [63:0] QNAN  = 64'h7FF8000000000000;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   flags;

  fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t        tab[$];
  logic [67:0] exp_q[$];
  int          acc_q[$];
  int          n_checks, n_fail, cyc, last_lat;
  logic        held;
  logic [67:0] held_val;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [63:0] va, input logic [63:0] vb, input logic vs,
                         input logic [63:0] vr, input logic [3:0] vf);
    vec_t v;
    v.a = va; v.b = vb; v.sub = vs; v.res = vr; v.flg = vf;
    tab.push_back(v);
  endtask

  // Exact arithmetic on integer significands, then rounding by remainder comparison
  function automatic logic [67:0] model(input logic [63:0] x, input logic [63:0] y, input logic sub);
    logic        sx, sy, sgn, inx, xnan, ynan, xinf, yinf;
    int          ex, ey, base, p, sh, e;
    logic [52:0] mx, my;
    logic [259:0] vx, vy, m, kept, rem, half;
    sx = x[63];
    sy = y[63] ^ sub;
    ex = int'(x[62:52]);
    ey = int'(y[62:52]);
    xnan = (ex == 2047) && (x[51:0] != 52'd0);
    ynan = (ey == 2047) && (y[51:0] != 52'd0);
    xinf = (ex == 2047) && (x[51:0] == 52'd0);
    yinf = (ey == 2047) && (y[51:0] == 52'd0);
    if (xnan || ynan) return {QNAN, 4'b1000};
    if (xinf && yinf) return (sx != sy) ? {QNAN, 4'b1000} : {sx, 11'h7FF, 52'd0, 4'b0000};
    if (xinf) return {sx, 11'h7FF, 52'd0, 4'b0000};
    if (yinf) return {sy, 11'h7FF, 52'd0, 4'b0000};
    if (ex == 0 && ey == 0) return {sx & sy, 63'd0, 4'b0000};
    if (ex == 0) return {sy, y[62:0], 4'b0000};
    if (ey == 0) return {sx, x[62:0], 4'b0000};
    mx = {1'b1, x[51:0]};
    my = {1'b1, y[51:0]};
    // Beyond 150 binades the smaller operand is far below half an ulp; a unit stand-in keeps its sign effect
    if (ex - ey > 150)      base = ex - 150;
    else if (ey - ex > 150) base = ey - 150;
    else                    base = (ex < ey) ? ex : ey;
    vx = (ex >= base) ? (260'(mx) << (ex - base)) : 260'd1;
    vy = (ey >= base) ? (260'(my) << (ey - base)) : 260'd1;
    if (vx >= vy) begin
      m   = (sx == sy) ? vx + vy : vx - vy;
      sgn = sx;
    end else begin
      m   = (sx == sy) ? vx + vy : vy - vx;
      sgn = sy;
    end
    if (m == 260'd0) return {64'd0, 4'b0000};
    p = 0;
    for (int i = 0; i < 260; i++) if (m[i]) p = i;
    e = base + p - 52;
    if (e <= 0) return {sgn, 63'd0, 4'b0011};
    if (p > 52) begin
      sh   = p - 52;
      kept = m >> sh;
      rem  = m & ((260'd1 << sh) - 260'd1);
      half = 260'd1 << (sh - 1);
      inx  = (rem != 260'd0);
`ifdef FP_ADD_RNE_EN
      if (rem > half || (rem == half && kept[0])) kept = kept + 260'd1;
`endif
      if (kept[53]) begin
        kept = kept >> 1;
        e    = e + 1;
      end
    end else begin
      kept = m << (52 - p);
      inx  = 1'b0;
    end
    if (e >= 2047) return {sgn, 11'h7FF, 52'd0, 4'b0101};
    return {sgn, 11'(e), kept[51:0], 3'b000, inx};
  endfunction

  function automatic logic [63:0] rand_op(input int e_ref);
    logic [63:0] r;
    int k, e;
    r = {$urandom, $urandom};
    k = int'($urandom_range(0, 15));
    if (k == 0) e = 0;
    else if (k == 1) begin
      e = 2047;
      if ($urandom_range(0, 1) == 0) r[51:0] = 52'd0;
    end else if (k == 2) e = int'($urandom_range(1, 2046));
    else begin
      e = e_ref + int'($urandom_range(0, 140)) - 70;
      if (e < 1) e = 1;
      if (e > 2046) e = 2046;
    end
    if ($urandom_range(0, 3) == 0) r[40:0] = 41'd0;
    r[62:52] = 11'(e);
    return r;
  endfunction

  // One cycle: drive at negedge, then observe output handshake and input acceptance
  task automatic step(input logic v, input logic [63:0] aa, input logic [63:0] bb,
                      input logic s, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid = v; a = aa; b = bb; op_sub = s; out_ready = ordy;
    #1;
    cyc++;
    if (held) begin
      chk("hold_valid", 68'(out_valid), 68'(1'b1));
      chk("hold_data", {result, flags}, held_val);
    end
    held = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: got %h with no beat outstanding", {result, flags});
        end else begin
          chk("result_flags", {result, flags}, exp_q.pop_front());
          last_lat = cyc - acc_q.pop_front();
        end
      end else begin
        held     = 1'b1;
        held_val = {result, flags};
      end
    end
    acc = v && in_ready;
    if (acc) acc_q.push_back(cyc);
  endtask

  task automatic drain(input int budget);
    logic acc;
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, acc);
      k++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, saw_stall;
    int tries, j;
    n_checks = 0; n_fail = 0; cyc = 0; last_lat = 0; held = 1'b0; held_val = '0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 68'(out_valid), 68'(1'b0));
    chk("reset_result_flags", {result, flags}, 68'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 68'(in_ready), 68'(1'b1));

    add_vec(64'h3FF8000000000000, 64'h3FF8000000000000, 1'b0, 64'h4008000000000000, 4'b0000);
    add_vec(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000, 4'b0000);
`ifdef FP_ADD_RNE_EN
    add_vec(64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000002, 4'b0001);
    add_vec(64'h3FF0000000000000, 64'h3C30000000000000, 1'b1, 64'h3FF0000000000000, 4'b0001);
`else
    add_vec(64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000001, 4'b0001);
    add_vec(64'h3FF0000000000000, 64'h3C30000000000000, 1'b1, 64'h3FEFFFFFFFFFFFFF, 4'b0001);
`endif
    add_vec(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 4'b0101);
    add_vec(64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 64'h7FF8000000000000, 4'b1000);
    add_vec(64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, 64'h7FF0000000000000, 4'b0000);
    add_vec(64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h8000000000000000, 4'b0000);
    add_vec(64'h0000000000000000, 64'h8000000000000000, 1'b0, 64'h0000000000000000, 4'b0000);
    add_vec(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 4'b1000);
    add_vec(64'hFFF0000000000000, 64'h3FF0000000000000, 1'b0, 64'hFFF0000000000000, 4'b0000);
    add_vec(64'h3FF0000000000000, 64'h0000000000000001, 1'b0, 64'h3FF0000000000000, 4'b0000);
    add_vec(64'h0010000000000001, 64'h0010000000000000, 1'b1, 64'h0000000000000000, 4'b0011);
    add_vec(64'h0020000000000000, 64'h0010000000000000, 1'b1, 64'h0010000000000000, 4'b0000);
    add_vec(64'h3FF0000000000000, 64'h3FF0000000000001, 1'b1, 64'hBCB0000000000000, 4'b0000);
    add_vec(64'h3FF0000000000000, 64'h3C30000000000000, 1'b0, 64'h3FF0000000000000, 4'b0001);
    add_vec(64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000, 4'b0000);

    foreach (tab[i]) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 8) begin
        step(1'b1, tab[i].a, tab[i].b, tab[i].sub, 1'b1, acc);
        tries++;
      end
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: vector %0d never accepted", i);
      end else begin
        exp_q.push_back({tab[i].res, tab[i].flg});
        last_lat = -1;
        drain(20);
        chk("latency", 68'(last_lat), 68'(3));
      end
    end

    for (int t = 0; t < 800; t++) begin
      logic [63:0] ra, rb;
      logic rs, rv, ro;
      int eref;
      case ($urandom_range(0, 2))
        0:       eref = int'($urandom_range(1, 60));
        1:       eref = int'($urandom_range(1990, 2046));
        default: eref = int'($urandom_range(900, 1100));
      endcase
      ra = rand_op(eref);
      rb = ($urandom_range(0, 9) == 0) ? ra : rand_op(eref);
      rs = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 9) < 7);
      ro = ($urandom_range(0, 3) != 0);
      step(rv, ra, rb, rs, ro, acc);
      if (acc) exp_q.push_back(model(ra, rb, rs));
    end
    drain(50);

    j = 0;
    saw_stall = 1'b0;
    for (int t = 0; t < 40 && (j < 5 || exp_q.size() > 0); t++) begin
      logic [63:0] ra, rb;
      ra = rand_op(1023);
      rb = rand_op(1023);
      step(j < 5, ra, rb, 1'b0, t >= 4, acc);
      if (!in_ready) saw_stall = 1'b1;
      if (acc) begin
        exp_q.push_back(model(ra, rb, 1'b0));
        j++;
      end
    end
    chk("stall_in_ready_drop", 68'(saw_stall), 68'(1'b1));
    chk("stall_beats_accepted", 68'(j), 68'(5));
    drain(20);

    for (int t = 0; t < 4; t++) begin
      logic [63:0] ra, rb;
      ra = rand_op(1023);
      rb = rand_op(1023);
      step(1'b1, ra, rb, 1'b1, 1'b1, acc);
      if (acc) exp_q.push_back(model(ra, rb, 1'b1));
    end
    chk("pre_reset_out_valid", 68'(out_valid), 68'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async_reset_out_valid", 68'(out_valid), 68'(1'b0));
    @(negedge clk);
    #1;
    chk("reset_mid_out_valid", 68'(out_valid), 68'(1'b0));
    chk("reset_mid_in_ready", 68'(in_ready), 68'(1'b1));
    exp_q.delete();
    acc_q.delete();
    held = 1'b0;
    rst  = 1'b0;
    for (int t = 0; t < 6; t++) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, acc);

    step(1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1'b1, acc);
    if (acc) exp_q.push_back({64'h4000000000000000, 4'b0000});
    chk("post_reset_accept", 68'(acc), 68'(1'b1));
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
